// File: rtl/button_debounce_reader.sv
// Button input: 2-flop synchronizer, debounce FSM, press counter and pulses.
// Define BUTTON_LONG_PRESS_EN to add the long-press hold timer and long_pulse.
module button_debounce_reader #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter bit          ACTIVE_LOW        = 1'b1,
    parameter int unsigned CNT_W             = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);
    localparam int unsigned     DW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t          state;
    logic [DW-1:0]   deb_cnt;
    logic            sync1;
    logic            sync2;
    logic            btn_act;
    logic            press_accept;

    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_param_check
        $error("button_debounce_reader: cycle parameters must be >= 2");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign btn_act      = sync2 ^ ACTIVE_LOW;
    assign press_accept = (state == PRESS_WAIT) && btn_act && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RELEASED;
            deb_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (btn_act) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_act) begin
                        state   <= RELEASED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= PRESSED;
                        deb_cnt     <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_act) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // Bounce back to PRESSED keeps btn_level high and the count untouched.
                    if (btn_act) begin
                        state   <= PRESSED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= RELEASED;
                        deb_cnt       <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= RELEASED;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int unsigned   LW        = $clog2(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_PRESS_CYCLES - 1);

    logic [LW-1:0] hold_cnt;
    logic          long_done;

    // Counter saturates at LONG_PRESS_CYCLES-1; long_done limits firing to once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            long_done  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (press_accept) begin
                hold_cnt  <= '0;
                long_done <= 1'b0;
            end else if (state == PRESSED) begin
                if (hold_cnt != HOLD_LAST) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end else if (!long_done) begin
                    long_pulse <= 1'b1;
                    long_done  <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = press_accept;
    assign long_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce_reader.sv
// Randomized bench for button_debounce_reader against a run-length debounce model.
module tb_button_debounce_reader;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 16;
    localparam bit          AL   = 1'b1;
    localparam int unsigned CW   = 2;
    localparam bit          PR   = ~AL;
    localparam bit          IN   = AL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btn_raw;
    logic          btn_level;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_pulse;
    logic [CW-1:0] press_count;

    int total = 0;
    int bad   = 0;
    int press_seen = 0;
    int rel_seen   = 0;

    button_debounce_reader #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .ACTIVE_LOW       (AL),
        .CNT_W            (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    // Model: accepted level flips once DEB+1 consecutive samples disagree with it.
    typedef struct {
        bit lvl;
        int run;
        int held;
        int cnt;
        bit p;
        bit r;
        bit l;
    } mst_t;

    mst_t m;
    bit   q1, q2;

    function automatic mst_t mstep(mst_t s, bit a);
        mst_t n;
        n   = s;
        n.p = 1'b0;
        n.r = 1'b0;
        n.l = 1'b0;
        if (s.lvl && s.run == 0) begin
            n.held = s.held + 1;
            if (n.held == LONG) n.l = 1'b1;
        end
        n.run = (a != s.lvl) ? s.run + 1 : 0;
        if (n.run == DEB + 1) begin
            n.run = 0;
            n.lvl = !s.lvl;
            if (n.lvl) begin
                n.p    = 1'b1;
                n.cnt  = (s.cnt + 1) % (1 << CW);
                n.held = 0;
            end else begin
                n.r = 1'b1;
            end
        end
`ifndef BUTTON_LONG_PRESS_EN
        n.l = 1'b0;
`endif
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m  <= '{lvl: 1'b0, run: 0, held: 0, cnt: 0, p: 1'b0, r: 1'b0, l: 1'b0};
            q1 <= IN;
            q2 <= IN;
        end else begin
            m  <= mstep(m, q2 != IN);
            q1 <= btn_raw;
            q2 <= q1;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("btn_level", int'(btn_level), int'(m.lvl));
        chk("press_pulse", int'(press_pulse), int'(m.p));
        chk("release_pulse", int'(release_pulse), int'(m.r));
        chk("long_pulse", int'(long_pulse), int'(m.l));
        chk("press_count", int'(press_count), m.cnt);
        if (press_pulse === 1'b1) press_seen++;
        if (release_pulse === 1'b1) rel_seen++;
    end

    task automatic drive(input bit pressed, input int cyc);
        @(negedge clk);
        btn_raw = pressed ? PR : IN;
        repeat (cyc - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Edge 1 is the first posedge after the call; records first pulse edges.
    task automatic watch(input int n, output int pe, output int re, output int le, output int lc);
        pe = 0; re = 0; le = 0; lc = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (press_pulse && pe == 0) pe = i;
            if (release_pulse && re == 0) re = i;
            if (long_pulse) begin
                lc++;
                if (le == 0) le = i;
            end
        end
    endtask

    initial begin
        int pe, re, le, lc, base, base_r;
        rst_n   = 1'b0;
        btn_raw = IN;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_level", int'(btn_level), 0);
        chk("reset_count", int'(press_count), 0);
        chk("reset_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press then hold long enough for the long-press timer.
        @(negedge clk);
        btn_raw = PR;
        watch(45, pe, re, le, lc);
        chk("press_edge", pe, 7);
        chk("press_level", int'(btn_level), 1);
        chk("press_count1", int'(press_count), 1);
`ifdef BUTTON_LONG_PRESS_EN
        chk("long_count", lc, 1);
        chk("long_edge", le, 23);
`else
        chk("long_count", lc, 0);
`endif

        @(negedge clk);
        btn_raw = IN;
        watch(12, pe, re, le, lc);
        chk("release_edge", re, 7);
        chk("release_level", int'(btn_level), 0);

        // Press-side bounce: no accepted press.
        base = press_seen;
        drive(1, 3);
        drive(0, 2);
        drive(1, 2);
        drive(0, 12);
        chk("bounce_pulses", press_seen - base, 0);
        chk("bounce_count", int'(press_count), 1);
        chk("bounce_level", int'(btn_level), 0);

        // Release-side bounce while pressed.
        drive(1, 12);
        base_r = rel_seen;
        drive(0, 2);
        drive(1, 12);
        chk("rbounce_pulses", rel_seen - base_r, 0);
        chk("rbounce_level", int'(btn_level), 1);
        chk("rbounce_count", int'(press_count), 2);
        drive(0, 12);
        chk("rbounce_release", rel_seen - base_r, 1);

        // Counter wrap with a 2-bit count.
        do_reset();
        base = press_seen;
        for (int k = 1; k <= 4; k++) begin
            drive(1, 10);
            chk("wrap_count", int'(press_count), k % 4);
            drive(0, 10);
        end
        chk("wrap_pulses", press_seen - base, 4);

        // Reset while pressed with the pin still held.
        drive(1, 10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_level", int'(btn_level), 0);
        chk("midreset_count", int'(press_count), 0);
        chk("midreset_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        watch(15, pe, re, le, lc);
        chk("midreset_press_edge", pe, 7);
        chk("midreset_count1", int'(press_count), 1);

        // Random run lengths around the debounce threshold, occasional reset.
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
        end
        drive(0, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
